// File: rtl/data_mem_pkg.sv
// Shared FSM state type and parameter defaults for the data memory unit.
package data_mem_pkg;

    localparam int DEFAULT_DEPTH   = 256;
    localparam int DEFAULT_LATENCY = 2;
    localparam int WORD_W          = 64;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64-bit storage: synchronous write, registered read, shared index.
module dmem_array
    import data_mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] index,
    input  logic [WORD_W-1:0]        wr_data,
    output logic [WORD_W-1:0]        rd_data
);

    logic [WORD_W-1:0] mem [DEPTH];

    // NOTE: storage and read register have no reset, so they map onto plain RAM;
    // non-blocking assignments keep the read returning the pre-write word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[index] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[index];
        end
    end

endmodule

// File: rtl/data_memory_unit.sv
// Load/store data memory with valid/ready handshakes, fixed latency and fault decode.
module data_memory_unit
    import data_mem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [63:0] Address,
    input  logic [63:0] WriteData,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [63:0] ReadData,
    output logic        Fault
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    typedef struct packed {
        logic             fault;
        logic             load;
        logic             store;
        logic [IDX_W-1:0] index;
        logic [63:0]      wdata;
    } req_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    req_t             in_req;
    req_t             held_req;
    req_t             cur_req;
    logic             resp_load;
    logic             enter_resp;
    logic [63:0]      rd_data;

    // NOTE: every field is assigned on every pass, so no latch can be inferred.
    always_comb begin
        in_req.fault = (Address[2:0] != 3'd0) || (Address[63:IDX_W+3] != '0)
                       || (MemRead && MemWrite);
        in_req.load  = MemRead;
        in_req.store = MemWrite;
        in_req.index = Address[IDX_W+2:3];
        in_req.wdata = WriteData;
    end

    // With LATENCY==1 the memory is accessed on the accept edge, before the latch holds it.
    assign cur_req    = (state == IDLE) ? in_req : held_req;
    assign enter_resp = !Reset && (((state == IDLE) && ReqValid && (LATENCY == 1))
                                   || ((state == WAIT) && (count == '0)));

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (Clock),
        .wr_en   (enter_resp && cur_req.store && !cur_req.fault),
        .rd_en   (enter_resp && cur_req.load && !cur_req.fault),
        .index   (cur_req.index),
        .wr_data (cur_req.wdata),
        .rd_data (rd_data)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            count     <= '0;
            ReqReady  <= 1'b1;
            RespValid <= 1'b0;
            Fault     <= 1'b0;
            resp_load <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ReqValid) begin
                        held_req <= in_req;
                        ReqReady <= 1'b0;
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            RespValid <= 1'b1;
                            Fault     <= in_req.fault;
                            resp_load <= in_req.load && !in_req.fault;
                        end else begin
                            state <= WAIT;
                            count <= CNT_W'(LATENCY - 2);
                        end
                    end
                end
                WAIT: begin
                    if (count == '0) begin
                        state     <= RESP;
                        RespValid <= 1'b1;
                        Fault     <= held_req.fault;
                        resp_load <= held_req.load && !held_req.fault;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                RESP: begin
                    if (RespReady) begin
                        state     <= IDLE;
                        ReqReady  <= 1'b1;
                        RespValid <= 1'b0;
                        Fault     <= 1'b0;
                        resp_load <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ReadData = resp_load ? rd_data : '0;

endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit: two instances (LATENCY 2 / DEPTH 256, LATENCY 1 / DEPTH 16) vs a word-array model.
module tb_data_memory_unit;

    localparam int DEPTH0 = 256;
    localparam int LAT0   = 2;
    localparam int DEPTH1 = 16;
    localparam int LAT1   = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        mem_read   [2];
    logic        mem_write  [2];
    logic [63:0] address    [2];
    logic [63:0] write_data [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [63:0] read_data  [2];
    logic        fault      [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [63:0] model [2][DEPTH0];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_unit #(.DEPTH(DEPTH0), .LATENCY(LAT0)) u_dut0 (
        .Clock(clk), .Reset(reset), .ReqValid(req_valid[0]), .ReqReady(req_ready[0]),
        .MemRead(mem_read[0]), .MemWrite(mem_write[0]), .Address(address[0]),
        .WriteData(write_data[0]), .RespValid(resp_valid[0]), .RespReady(resp_ready[0]),
        .ReadData(read_data[0]), .Fault(fault[0])
    );

    data_memory_unit #(.DEPTH(DEPTH1), .LATENCY(LAT1)) u_dut1 (
        .Clock(clk), .Reset(reset), .ReqValid(req_valid[1]), .ReqReady(req_ready[1]),
        .MemRead(mem_read[1]), .MemWrite(mem_write[1]), .Address(address[1]),
        .WriteData(write_data[1]), .RespValid(resp_valid[1]), .RespReady(resp_ready[1]),
        .ReadData(read_data[1]), .Fault(fault[1])
    );

    function automatic int depth_of(input int d);
        return (d == 0) ? DEPTH0 : DEPTH1;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called and returns at a falling edge; hold = extra cycles RespReady stays low.
    task automatic transact(input int d, input logic rd, input logic wr,
                            input logic [63:0] addr, input logic [63:0] wdata,
                            input int hold, input string tag, output int acc_cyc);
        logic        exp_flt;
        logic [63:0] exp_data;
        int          n;
        exp_flt  = (addr[2:0] != 3'd0) || (addr >= 64'(depth_of(d)) * 64'd8) || (rd && wr);
        exp_data = '0;
        if (!exp_flt && wr) model[d][int'(addr >> 3)] = wdata;
        if (!exp_flt && rd) exp_data = model[d][int'(addr >> 3)];

        n = 0;
        while (req_ready[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "/ready"}, 64'(req_ready[d]), 64'd1);
        req_valid[d]  = 1'b1;
        mem_read[d]   = rd;
        mem_write[d]  = wr;
        address[d]    = addr;
        write_data[d] = wdata;
        resp_ready[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        check({tag, "/busy"}, 64'(req_ready[d]), 64'd0);

        // Scramble inputs after accept: the latched request must be unaffected.
        req_valid[d]  = 1'($urandom);
        mem_read[d]   = 1'($urandom);
        mem_write[d]  = 1'($urandom);
        address[d]    = {$urandom, $urandom};
        write_data[d] = {$urandom, $urandom};

        n = 1;
        while (resp_valid[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "/latency"}, 64'(n), 64'(lat_of(d)));
        req_valid[d] = 1'b0;

        for (int i = 0; i <= hold; i++) begin
            check({tag, "/valid"}, 64'(resp_valid[d]), 64'd1);
            check({tag, "/data"},  read_data[d], exp_data);
            check({tag, "/fault"}, 64'(fault[d]), 64'(exp_flt));
            check({tag, "/noready"}, 64'(req_ready[d]), 64'd0);
            if (i < hold) @(negedge clk);
        end

        resp_ready[d] = 1'b1;
        @(negedge clk);
        resp_ready[d] = 1'b0;
        check({tag, "/done_valid"}, 64'(resp_valid[d]), 64'd0);
        check({tag, "/done_data"},  read_data[d], 64'd0);
        check({tag, "/done_fault"}, 64'(fault[d]), 64'd0);
        check({tag, "/idle_ready"}, 64'(req_ready[d]), 64'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          acc;
        int          prev;
        logic [63:0] addr;

        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d]  = 1'b0;
            mem_read[d]   = 1'b0;
            mem_write[d]  = 1'b0;
            address[d]    = '0;
            write_data[d] = '0;
            resp_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_valid", 64'(resp_valid[d]), 64'd0);
            check("rst_data",  read_data[d], 64'd0);
            check("rst_fault", 64'(fault[d]), 64'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) check("rst_ready", 64'(req_ready[d]), 64'd1);

        // Fill every word so later loads have known contents; also checks back-to-back rate.
        for (int d = 0; d < 2; d++) begin
            prev = 0;
            for (int w = 0; w < depth_of(d); w++) begin
                transact(d, 1'b0, 1'b1, 64'(w) * 64'd8, {$urandom, $urandom}, 0, "fill", acc);
                if (w > 0) check("throughput", 64'(acc - prev), 64'(lat_of(d) + 1));
                prev = acc;
            end
        end

        transact(0, 1'b0, 1'b1, 64'h10, 64'hDEADBEEFCAFEF00D, 0, "st10", acc);
        transact(0, 1'b1, 1'b0, 64'h10, 64'h0, 0, "ld10", acc);
        check("ld10_model", model[0][2], 64'hDEADBEEFCAFEF00D);
        transact(0, 1'b0, 1'b1, 64'h13, 64'h1111_2222_3333_4444, 0, "st_misalign", acc);
        transact(0, 1'b1, 1'b0, 64'h10, 64'h0, 0, "ld_after_misalign", acc);
        transact(0, 1'b1, 1'b0, 64'h800, 64'h0, 0, "ld_oor", acc);
        transact(0, 1'b1, 1'b0, 64'h7F8, 64'h0, 0, "ld_last", acc);
        transact(1, 1'b1, 1'b0, 64'h80, 64'h0, 0, "ld_oor1", acc);
        transact(1, 1'b1, 1'b0, 64'h78, 64'h0, 0, "ld_last1", acc);
        transact(0, 1'b1, 1'b0, 64'h10, 64'h0, 5, "backpressure", acc);
        transact(0, 1'b0, 1'b0, 64'h18, 64'h5, 2, "noop", acc);

        // Store accepted, then reset on the edge that would have entered RESP.
        address[0]    = 64'h20;
        write_data[0] = 64'h1;
        mem_write[0]  = 1'b1;
        mem_read[0]   = 1'b0;
        req_valid[0]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        check("abort_valid", 64'(resp_valid[0]), 64'd0);
        check("abort_fault", 64'(fault[0]), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", 64'(req_ready[0]), 64'd1);
        transact(0, 1'b1, 1'b0, 64'h20, 64'h0, 0, "ld_after_abort", acc);

        for (int d = 0; d < 2; d++) begin
            transact(d, 1'b1, 1'b1, 64'h8, 64'hFFFF_0000_FFFF_0000, 0, "conflict", acc);
            transact(d, 1'b1, 1'b0, 64'h8, 64'h0, 0, "ld_after_conflict", acc);
        end

        for (int k = 0; k < 400; k++) begin
            int d;
            d = k % 2;
            case ($urandom_range(0, 3))
                0, 1:    addr = 64'($urandom_range(0, depth_of(d) - 1)) * 64'd8;
                2:       addr = 64'($urandom_range(0, depth_of(d) * 8 - 1)) | 64'd1;
                default: addr = 64'(depth_of(d)) * 64'd8 + 64'($urandom_range(0, 4095)) * 64'd8;
            endcase
            transact(d, 1'($urandom), 1'($urandom), addr, {$urandom, $urandom},
                     $urandom_range(0, 3), "random", acc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory_unit.md
DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 64-bit words; power of two, at least 2.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request accept to response valid; at least 1.
REQ-003 SHALL have port Clock, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ReqValid, input, 1 bit: a request is presented.
REQ-006 SHALL have port ReqReady, output, 1 bit: the unit can accept a request.
REQ-007 SHALL have port MemRead, input, 1 bit: the request is a load (LDUR).
REQ-008 SHALL have port MemWrite, input, 1 bit: the request is a store (STUR).
REQ-009 SHALL have port Address, input, 64 bits: byte address, taken from ALU BusW.
REQ-010 SHALL have port WriteData, input, 64 bits: store data.
REQ-011 SHALL have port RespValid, output, 1 bit: the response is valid.
REQ-012 SHALL have port RespReady, input, 1 bit: the consumer accepts the response.
REQ-013 SHALL have port ReadData, output, 64 bits: load result.
REQ-014 SHALL have port Fault, output, 1 bit: the request was rejected.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 SHALL assert ReqReady only in IDLE; a request is accepted on a rising edge where ReqValid && ReqReady.
REQ-017 SHALL latch MemRead, MemWrite, Address and WriteData at accept; input changes after accept SHALL have no effect.
REQ-018 SHALL go IDLE->RESP on accept when LATENCY==1; otherwise IDLE->WAIT, loading a down-counter with LATENCY-2.
REQ-019 SHALL go WAIT->RESP on the edge where the counter equals 0; otherwise decrement the counter.
REQ-020 SHALL make RespValid rise exactly LATENCY edges after the accept edge.
REQ-021 SHALL assert RespValid only in RESP.
REQ-022 SHALL go RESP->IDLE on an edge where RespReady is 1; otherwise hold RESP with ReadData and Fault stable.
REQ-023 SHALL give back-to-back throughput of one request per LATENCY+1 cycles when RespReady is held 1.
REQ-024 SHALL use word index Address[log2(DEPTH)+2:3].
REQ-025 SHALL flag a fault if Address[2:0]!=0 (misaligned) or Address>=DEPTH*8 (out of range).
REQ-026 SHALL flag a fault if MemRead and MemWrite are both 1.
REQ-027 SHALL, on a fault, set Fault=1 and ReadData=0 in RESP and leave memory unmodified; fault timing SHALL equal normal timing.
REQ-028 SHALL, for a load, capture mem[index] on the edge entering RESP and present it on ReadData; Fault=0.
REQ-029 SHALL, for a store, write WriteData to mem[index] on the edge entering RESP; ReadData=0, Fault=0.
REQ-030 SHALL treat a request with MemRead=0 and MemWrite=0 as a no-op: full latency, ReadData=0, Fault=0, no memory change.
REQ-031 SHALL ignore ReqValid outside IDLE.
REQ-032 SHALL drive ReadData=0 and Fault=0 whenever RespValid=0.

Reset
REQ-033 SHALL, on Reset=1 at an edge, force the state to IDLE, the counter to 0, RespValid=0, ReadData=0 and Fault=0, overriding all other inputs.
REQ-034 SHALL make ReqReady=1 in the cycle after reset deasserts.
REQ-035 SHALL NOT reset memory contents.
REQ-036 SHALL abort any in-flight request when Reset is asserted mid-operation; an aborted store SHALL NOT write memory, including when Reset coincides with the RESP-entry edge.

Structure
REQ-037 SHALL place the FSM state enum (IDLE/WAIT/RESP) and the DEPTH/LATENCY defaults in shared package data_mem_pkg.
REQ-038 SHALL contain one sub-module, dmem_array: DEPTH x 64 storage with synchronous write and registered read.
REQ-039 SHALL keep the FSM, counter, fault decode and request latch in the top-level data_memory_unit.

Verification
REQ-040 SHALL test a store then a load: store Address=0x10 WriteData=0xDEADBEEFCAFEF00D, then load 0x10 -> ReadData=0xDEADBEEFCAFEF00D, Fault=0, RespValid exactly 2 edges after each accept.
REQ-041 SHALL test misalignment: store Address=0x13 -> Fault=1; a following load of 0x10 still returns the prior value.
REQ-042 SHALL test out of range: load Address=0x800 with DEPTH=256 -> Fault=1, ReadData=0; load 0x7F8 -> Fault=0.
REQ-043 SHALL test response backpressure: hold RespReady=0 for 5 cycles -> RespValid and ReadData stable, ReqReady=0; RespReady=1 -> IDLE on the next edge.
REQ-044 SHALL test reset mid-operation: store 0x20=0x1 accepted, Reset asserted at the next edge -> RespValid=0; a subsequent load of 0x20 returns the old contents.
REQ-045 SHALL test conflicting flags: MemRead=MemWrite=1 at 0x8 -> Fault=1 and memory unchanged; repeat at LATENCY=1 -> RespValid 1 edge after accept.
